// File: rtl/ula_resultado_bcd.sv
// Purpose  : latch a finished ULA result with its erro/overflow flags and convert it to signed packed BCD.
// Latency  : done pulses LARGURA+1 edges after start is accepted (1 edge on the erro path).
// Backpres.: start is only sampled while idle; requests during a conversion are dropped, not queued.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   start                    conversion request, sampled only when ocupado=0
//   resultado, modo_sinal    ULA word and signedness (1 = two's complement)
//   erro_in, overflow_in     ULA flags, captured together with resultado
//   ocupado                  conversion in progress
//   done                     one-cycle pulse; bcd/negativo/erro_out/overflow_out change only then
//   bcd                      packed BCD, most significant digit in the top nibble
//   negativo                 sign of the displayed value
//   erro_out, overflow_out   flags captured with the displayed value
module ula_resultado_bcd #(
    parameter int LARGURA = 8,
    parameter int DIGITOS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LARGURA-1:0]     resultado,
    input  logic                   modo_sinal,
    input  logic                   erro_in,
    input  logic                   overflow_in,
    output logic                   ocupado,
    output logic                   done,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   negativo,
    output logic                   erro_out,
    output logic                   overflow_out
);

    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t                r_estado;
    logic [4*DIGITOS-1:0]   r_scratch;
    logic [LARGURA-1:0]     r_mag;
    logic [CW-1:0]          r_cont;
    logic                   r_sinal;
    logic                   r_erro;
    logic                   r_ovf;

    logic                   r_ocupado;
    logic                   r_done;
    logic [4*DIGITOS-1:0]   r_bcd;
    logic                   r_negativo;
    logic                   r_erro_out;
    logic                   r_overflow_out;

    logic                   w_neg;
    logic [LARGURA-1:0]     w_mag;
    logic [4*DIGITOS-1:0]   w_ajust;

    assign w_neg = modo_sinal & resultado[LARGURA-1];

    // The largest magnitude is 2**(LARGURA-1) (most negative input), which still fits
    // in LARGURA unsigned bits, so the two's complement negate wrapping at LARGURA bits
    // gives the same pattern as the LARGURA+1 bit result with its always-zero top bit.
    assign w_mag = w_neg ? (~resultado + LARGURA'(1)) : resultado;

    // Double-dabble correction: any digit >= 5 would become >= 10 after the shift,
    // so pre-add 3 to carry it into the next nibble.
    always_comb begin
        w_ajust = r_scratch;
        for (int d = 0; d < DIGITOS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_ajust[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado       <= OCIOSO;
            r_scratch      <= '0;
            r_mag          <= '0;
            r_cont         <= '0;
            r_sinal        <= 1'b0;
            r_erro         <= 1'b0;
            r_ovf          <= 1'b0;
            r_ocupado      <= 1'b0;
            r_done         <= 1'b0;
            r_bcd          <= '0;
            r_negativo     <= 1'b0;
            r_erro_out     <= 1'b0;
            r_overflow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_sinal   <= w_neg;
                        r_mag     <= w_mag;
                        r_erro    <= erro_in;
                        r_ovf     <= overflow_in;
                        r_scratch <= '0;
                        r_cont    <= '0;
                        r_ocupado <= 1'b1;
                        // An erroneous result has no meaningful value to convert.
                        r_estado  <= erro_in ? CONCLUI : DESLOCA;
                    end
                end
                DESLOCA: begin
                    {r_scratch, r_mag} <= {w_ajust, r_mag} << 1;
                    r_cont             <= r_cont + 1'b1;
                    if (r_cont == CW'(LARGURA - 1))
                        r_estado <= CONCLUI;
                end
                CONCLUI: begin
                    if (r_erro) begin
                        r_bcd      <= {DIGITOS{4'hE}};
                        r_negativo <= 1'b0;
                    end else begin
                        r_bcd      <= r_scratch;
                        r_negativo <= r_sinal;
                    end
                    r_erro_out     <= r_erro;
                    r_overflow_out <= r_ovf;
                    r_done         <= 1'b1;
                    r_ocupado      <= 1'b0;
                    r_estado       <= OCIOSO;
                end
                default: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado      = r_ocupado;
    assign done         = r_done;
    assign bcd          = r_bcd;
    assign negativo     = r_negativo;
    assign erro_out     = r_erro_out;
    assign overflow_out = r_overflow_out;

endmodule

// File: tb/tb_ula_resultado_bcd.sv
module tb_ula_resultado_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  resultado;
    logic        modo_sinal;
    logic        erro_in;
    logic        overflow_in;
    logic        ocupado;
    logic        done;
    logic [11:0] bcd;
    logic        negativo;
    logic        erro_out;
    logic        overflow_out;

    ula_resultado_bcd #(.LARGURA(8), .DIGITOS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .resultado    (resultado),
        .modo_sinal   (modo_sinal),
        .erro_in      (erro_in),
        .overflow_in  (overflow_in),
        .ocupado      (ocupado),
        .done         (done),
        .bcd          (bcd),
        .negativo     (negativo),
        .erro_out     (erro_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic        m;
        logic        e;
        logic        o;
        logic [11:0] bcd;
        logic        neg;
    } vec_t;

    typedef struct {
        logic [11:0] bcd;
        logic        neg;
        logic        erro;
        logic        ovf;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with no request outstanding, required none (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("bcd",          32'(bcd),          32'(e.bcd));
                chk("negativo",     32'(negativo),     32'(e.neg));
                chk("erro_out",     32'(erro_out),     32'(e.erro));
                chk("overflow_out", 32'(overflow_out), 32'(e.ovf));
            end
        end
    end

    // Independent decimal model of the displayed value.
    function automatic exp_t model(input logic [7:0] r, input logic m, input logic e, input logic o);
        exp_t x;
        int   v;
        x.erro = e;
        x.ovf  = o;
        if (e) begin
            x.bcd = 12'hEEE;
            x.neg = 1'b0;
        end else begin
            v     = (m && r[7]) ? 256 - int'(r) : int'(r);
            x.neg = m && r[7];
            x.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        end
        return x;
    endfunction

    // Drive a request (caller is just after a rising edge) and record its expectation.
    task automatic issue(input logic [7:0] r, input logic m, input logic e, input logic o,
                         input logic [11:0] eb, input logic en);
        exp_t x;
        resultado   = r;
        modo_sinal  = m;
        erro_in     = e;
        overflow_in = o;
        start       = 1'b1;
        x.bcd = eb; x.neg = en; x.erro = e; x.ovf = o;
        sb.push_back(x);
    endtask

    // Wait for done starting n edges after the accepting edge; returns edge count.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        int n;
        issue(v.r, v.m, v.e, v.o, v.bcd, v.neg);
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_ocupado_after_start"}, 32'(ocupado), 32'd1);
        wait_done(0, n);
        chk({nm, "_latency"}, 32'(n), v.e ? 32'd1 : 32'd9);
        chk({nm, "_ocupado_in_done"}, 32'(ocupado), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done_width"}, 32'(done), 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        int   n;
        int   dones_before;
        vec_t v;
        exp_t x;

        tbl[0]  = '{8'd255, 1'b0, 1'b0, 1'b0, 12'h255, 1'b0};
        tbl[1]  = '{8'h80,  1'b1, 1'b0, 1'b0, 12'h128, 1'b1};
        tbl[2]  = '{8'hFF,  1'b1, 1'b0, 1'b0, 12'h001, 1'b1};
        tbl[3]  = '{8'h7F,  1'b1, 1'b0, 1'b0, 12'h127, 1'b0};
        tbl[4]  = '{8'h00,  1'b0, 1'b1, 1'b0, 12'hEEE, 1'b0};
        tbl[5]  = '{8'd42,  1'b0, 1'b0, 1'b1, 12'h042, 1'b0};
        tbl[6]  = '{8'h80,  1'b0, 1'b0, 1'b0, 12'h128, 1'b0};
        tbl[7]  = '{8'd9,   1'b0, 1'b0, 1'b0, 12'h009, 1'b0};
        tbl[8]  = '{8'hF6,  1'b1, 1'b0, 1'b0, 12'h010, 1'b1};
        tbl[9]  = '{8'd100, 1'b0, 1'b0, 1'b0, 12'h100, 1'b0};
        tbl[10] = '{8'h85,  1'b1, 1'b1, 1'b1, 12'hEEE, 1'b0};
        tbl[11] = '{8'd199, 1'b0, 1'b0, 1'b0, 12'h199, 1'b0};

        rst = 1'b0; start = 1'b0; resultado = '0;
        modo_sinal = 1'b0; erro_in = 1'b0; overflow_in = 1'b0;

        #12;
        chk("reset_outputs", 32'({ocupado, done, bcd, negativo, erro_out, overflow_out}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({ocupado, done}), 32'd0);

        for (int i = 0; i < 12; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v.r = 8'($urandom_range(0, 255));
            v.m = 1'($urandom_range(0, 1));
            v.e = 1'b0;
            v.o = 1'($urandom_range(0, 1));
            x = model(v.r, v.m, v.e, v.o);
            v.bcd = x.bcd; v.neg = x.neg;
            run(v, $sformatf("rnd%0d", i));
        end

        // Start during a conversion is dropped; start in the done cycle is accepted.
        dones_before = n_done;
        issue(8'd42, 1'b0, 1'b0, 1'b0, 12'h042, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resultado = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; resultado = 8'd7;
        wait_done(3, n);
        chk("busy_latency", 32'(n), 32'd9);
        issue(8'd99, 1'b0, 1'b0, 1'b0, 12'h099, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_width", 32'(done), 32'd0);
        chk("b2b_ocupado", 32'(ocupado), 32'd1);
        wait_done(0, n);
        chk("b2b_latency", 32'(n), 32'd9);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_done_count", 32'(n_done - dones_before), 32'd2);

        // Reset in the middle of a conversion aborts it without a done pulse.
        dones_before = n_done;
        issue(8'd200, 1'b0, 1'b0, 1'b0, 12'h200, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_outputs", 32'({ocupado, done, bcd, negativo, erro_out, overflow_out}), 32'd0);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - dones_before), 32'd0);
        chk("abort_idle", 32'(ocupado), 32'd0);
        v = '{8'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0};
        run(v, "post_reset");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
